// File: rtl/fsic_io_pkg.sv
// fsic_io_pkg: shared types, default sizes and lane-bit indexing for the io serializer
package fsic_io_pkg;
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_e;
  localparam int DEF_NUM_LANE = 12;
  localparam int DEF_RATIO = 4;
  function automatic int lane_bit(int l, int k, int ratio);
    return l * ratio + k;
  endfunction
endpackage

// File: rtl/fsic_sat_cnt.sv
// fsic_sat_cnt: saturating event counter with synchronous clear
module fsic_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst || clr) cnt_q <= '0;
    else if (inc && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt = cnt_q;
endmodule

// File: rtl/fsic_io_serializer.sv
// fsic_io_serializer: locks to the divided core clock and shifts each parallel word
// out LSB-first on every lane, one bit per ioclk.
module fsic_io_serializer
  import fsic_io_pkg::*;
#(
  parameter int NUM_LANE = DEF_NUM_LANE,
  parameter int RATIO    = DEF_RATIO,
  parameter int UCNT_W   = 16,
  parameter int ECNT_W   = 8
) (
  input  logic                      ioclk,
  input  logic                      ioclk_rst,
  input  logic                      en,
  input  logic                      coreclk_ref,
  input  logic [NUM_LANE*RATIO-1:0] tx_word,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [NUM_LANE-1:0]       txd,
  output logic                      tx_frame,
  output logic                      locked,
  output logic                      phase_err,
  input  logic                      cnt_clr,
  output logic [UCNT_W-1:0]         underflow_cnt,
  output logic [ECNT_W-1:0]         phase_err_cnt
);
  localparam int PW = $clog2(RATIO);
  localparam logic [PW-1:0] LAST = PW'(RATIO - 1);
  state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [NUM_LANE*RATIO-1:0] shreg_q, shreg_d;
  logic [NUM_LANE-1:0] txd_q, txd_d, word_b0, shreg_bk;
  logic ref_q, frame_q, frame_d, perr_q, perr_d;
  logic rise, run, slot, slip, uflow;

  assign rise = coreclk_ref & ~ref_q;
  assign run = state_q == RUN && en;
  assign slot = run && phase_q == '0;
  // a reference edge anywhere but the last bit slot means the divider slipped
  assign slip = run && rise && phase_q != LAST;
  assign uflow = slot && !tx_valid;
  assign tx_ready = state_q == RUN && phase_q == '0;
  assign locked = state_q == RUN;
  assign txd = txd_q;
  assign tx_frame = frame_q;
  assign phase_err = perr_q;

  for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
    logic [RATIO-1:0] lane_sh;
    assign lane_sh = shreg_q[lane_bit(l, 0, RATIO) +: RATIO];
    assign word_b0[l] = tx_word[lane_bit(l, 0, RATIO)];
    assign shreg_bk[l] = lane_sh[phase_q];
  end

  always_ff @(posedge ioclk)
    if (ioclk_rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      shreg_q <= '0;
      txd_q <= '0;
      ref_q <= 1'b0;
      frame_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      txd_q <= txd_d;
      ref_q <= coreclk_ref;
      frame_q <= frame_d;
      perr_q <= perr_d;
    end

  always_comb
    state_d = !en ? IDLE :
              state_q == IDLE ? ALIGN :
              (state_q == ALIGN && rise) ? RUN : state_q;

  always_comb begin
    phase_d = (!run || slip || phase_q == LAST) ? '0 : phase_q + 1'b1;
    shreg_d = !run ? '0 : slot ? (tx_valid ? tx_word : '0) : shreg_q;
    txd_d = !run ? '0 : slot ? (tx_valid ? word_b0 : '0) : shreg_bk;
    frame_d = slot;
    perr_d = slip;
  end

  fsic_sat_cnt #(.W(UCNT_W)) u_ucnt (
    .clk(ioclk), .rst(ioclk_rst), .inc(uflow), .clr(cnt_clr), .cnt(underflow_cnt)
  );

  fsic_sat_cnt #(.W(ECNT_W)) u_ecnt (
    .clk(ioclk), .rst(ioclk_rst), .inc(slip), .clr(cnt_clr), .cnt(phase_err_cnt)
  );
endmodule

// File: tb/tb_fsic_io_serializer.sv
// tb_fsic_io_serializer: directed + random stimulus checked cycle by cycle against
// a slot-arithmetic reference model of the serializer.
module tb_fsic_io_serializer;
  localparam int NL = 12;
  localparam int R = 4;

  logic ioclk = 1'b0, ioclk_rst = 1'b1, en = 1'b0, coreclk_ref = 1'b0;
  logic [NL*R-1:0] tx_word = '0;
  logic tx_valid = 1'b0, cnt_clr = 1'b0;
  logic tx_ready, tx_frame, locked, phase_err;
  logic [NL-1:0] txd;
  logic [15:0] underflow_cnt;
  logic [7:0] phase_err_cnt;

  fsic_io_serializer #(.NUM_LANE(NL), .RATIO(R), .UCNT_W(16), .ECNT_W(8)) dut (
    .ioclk(ioclk), .ioclk_rst(ioclk_rst), .en(en), .coreclk_ref(coreclk_ref),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
    .tx_frame(tx_frame), .locked(locked), .phase_err(phase_err), .cnt_clr(cnt_clr),
    .underflow_cnt(underflow_cnt), .phase_err_cnt(phase_err_cnt)
  );

  always #5 ioclk = ~ioclk;

  int checks = 0, errors = 0;
  int cyc = 0, anchor = 0, refcnt = 0;
  bit m_armed = 0, m_locked = 0, m_ref = 0, hold_req = 0, toggle_mode = 0, rnd = 0;
  logic [NL*R-1:0] cur = '0;
  logic [15:0] m_u = '0;
  logic [7:0] m_e = '0;

  function automatic logic [NL-1:0] lanes(logic [NL*R-1:0] w, int k);
    logic [NL-1:0] r;
    for (int l = 0; l < NL; l++) r[l] = w[l*R+k];
    return r;
  endfunction

  task automatic step();
    bit rise, e_frame, e_err;
    int ph;
    logic [NL-1:0] e_txd;
    rise = coreclk_ref && !m_ref;
    checks++;
    assert (tx_ready === (m_locked && ((cyc - anchor) % R == 0)))
      else begin errors++; $error("FAIL tx_ready cyc=%0d got=%b exp=%b", cyc, tx_ready, m_locked && ((cyc - anchor) % R == 0)); end
    checks++;
    assert (locked === m_locked)
      else begin errors++; $error("FAIL locked cyc=%0d got=%b exp=%b", cyc, locked, m_locked); end
    e_txd = '0; e_frame = 0; e_err = 0;
    if (ioclk_rst) begin
      m_armed = 0; m_locked = 0; m_ref = 0; m_u = '0; m_e = '0; cur = '0;
    end else begin
      ph = (cyc - anchor) % R;
      if (m_locked && en) begin
        if (ph == 0) begin
          cur = tx_valid ? tx_word : '0;
          e_frame = 1;
          if (!tx_valid && m_u != 16'hFFFF) m_u++;
        end
        e_txd = lanes(cur, ph);
        e_err = rise && ph != R - 1;
        if (e_err && m_e != 8'hFF) m_e++;
        if (rise) anchor = cyc + 1;
      end
      if (cnt_clr) begin m_u = '0; m_e = '0; end
      if (!en) begin m_armed = 0; m_locked = 0; end
      else if (!m_armed) m_armed = 1;
      else if (!m_locked && rise) begin m_locked = 1; anchor = cyc + 1; end
      m_ref = coreclk_ref;
    end
    cyc++;
    @(posedge ioclk); #1;
    checks++;
    assert (txd === e_txd)
      else begin errors++; $error("FAIL txd cyc=%0d got=%h exp=%h", cyc, txd, e_txd); end
    checks++;
    assert (tx_frame === e_frame)
      else begin errors++; $error("FAIL tx_frame cyc=%0d got=%b exp=%b", cyc, tx_frame, e_frame); end
    checks++;
    assert (phase_err === e_err)
      else begin errors++; $error("FAIL phase_err cyc=%0d got=%b exp=%b", cyc, phase_err, e_err); end
    checks++;
    assert (underflow_cnt === m_u)
      else begin errors++; $error("FAIL underflow_cnt cyc=%0d got=%0d exp=%0d", cyc, underflow_cnt, m_u); end
    checks++;
    assert (phase_err_cnt === m_e)
      else begin errors++; $error("FAIL phase_err_cnt cyc=%0d got=%0d exp=%0d", cyc, phase_err_cnt, m_e); end
  endtask

  task automatic tick();
    if (toggle_mode) coreclk_ref = ~coreclk_ref;
    else begin
      coreclk_ref = refcnt[1];
      if (hold_req && refcnt % 4 == 3) hold_req = 0;
      else refcnt++;
    end
    if (rnd) begin
      tx_word = (NL*R)'({$urandom(), $urandom()});
      tx_valid = $urandom_range(0, 3) != 0;
      cnt_clr = $urandom_range(0, 49) == 0;
      if ($urandom_range(0, 39) == 0) hold_req = 1;
    end
    step();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 16) begin tick(); n++; end
    checks++;
    assert (tx_ready === 1'b1)
      else begin errors++; $error("FAIL wait_ready timeout got=%b exp=1", tx_ready); end
  endtask

  logic [3:0] seq, frs, e4, f4;
  logic [7:0] e8;

  initial begin
    for (int i = 0; i < 3; i++) tick();
    ioclk_rst = 0; en = 1; tx_valid = 1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    assert (locked === 1'b1) else begin errors++; $error("FAIL lock got=%b exp=1", locked); end
    tx_word = (NL*R)'(4'b1011);
    wait_ready();
    for (int i = 0; i < 4; i++) begin tick(); seq[i] = txd[0]; frs[i] = tx_frame; end
    e4 = 4'b1011; f4 = 4'b0001;
    checks++;
    assert (seq === e4) else begin errors++; $error("FAIL data_seq got=%b exp=%b", seq, e4); end
    checks++;
    assert (frs === f4) else begin errors++; $error("FAIL data_frame got=%b exp=%b", frs, f4); end
    tx_word = {NL{4'hA}};
    wait_ready();
    e8 = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) tx_word = {NL{4'h5}};
      checks++;
      assert (txd === {NL{e8[i]}})
        else begin errors++; $error("FAIL b2b bit%0d got=%h exp=%h", i, txd, {NL{e8[i]}}); end
    end
    wait_ready();
    tx_valid = 0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    assert (underflow_cnt === 16'd3) else begin errors++; $error("FAIL underflow3 got=%0d exp=3", underflow_cnt); end
    tx_valid = 1; cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++;
    assert (underflow_cnt === 16'd0) else begin errors++; $error("FAIL underflow_clr got=%0d exp=0", underflow_cnt); end
    hold_req = 1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    assert (phase_err_cnt === 8'd1) else begin errors++; $error("FAIL slip_cnt got=%0d exp=1", phase_err_cnt); end
    checks++;
    assert (locked === 1'b1) else begin errors++; $error("FAIL slip_locked got=%b exp=1", locked); end
    for (int i = 0; i < 8; i++) tick();
    rnd = 1;
    for (int i = 0; i < 300; i++) tick();
    rnd = 0; hold_req = 0; cnt_clr = 0; tx_valid = 1;
    for (int i = 0; i < 8; i++) tick();
    wait_ready();
    tick(); tick();
    en = 0;
    tick();
    checks++;
    assert (txd === '0 && locked === 1'b0 && tx_frame === 1'b0 && tx_ready === 1'b0)
      else begin errors++; $error("FAIL en_drop got=%h/%b/%b/%b exp=0/0/0/0", txd, locked, tx_frame, tx_ready); end
    en = 1;
    for (int i = 0; i < 12; i++) tick();
    wait_ready();
    tick();
    ioclk_rst = 1;
    tick();
    checks++;
    assert (txd === '0 && tx_frame === 1'b0 && locked === 1'b0 && phase_err === 1'b0 &&
            underflow_cnt === '0 && phase_err_cnt === '0 && tx_ready === 1'b0)
      else begin errors++; $error("FAIL reset_mid got=%h/%b/%b/%b/%0d/%0d exp=all0", txd, tx_frame, locked, phase_err, underflow_cnt, phase_err_cnt); end
    ioclk_rst = 0;
    toggle_mode = 1;
    for (int i = 0; i < 600; i++) tick();
    checks++;
    assert (phase_err_cnt === 8'hFF) else begin errors++; $error("FAIL ecnt_sat got=%0d exp=255", phase_err_cnt); end
    checks++;
    assert (locked === 1'b1) else begin errors++; $error("FAIL sat_locked got=%b exp=1", locked); end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++;
    assert (phase_err_cnt === 8'd0) else begin errors++; $error("FAIL ecnt_clr got=%0d exp=0", phase_err_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsic_io_serializer.md
Name: fsic_io_serializer

Overview:
- Transmit-side serializer for io_serdes, running on the fast ioclk.
- Sits directly downstream of the coreclk divider.
- Samples the divided clock (coreclk_ref) as a phase reference and locks a phase counter to its rising edge.
- Each coreclk period, accepts one parallel word and shifts it out LSB-first on NUM_LANE serial lanes, one bit per ioclk.

Parameters:
- NUM_LANE, 12, number of serial lanes.
- RATIO, 4, ioclk cycles per coreclk period; bits per lane per word. Must be ≥2.
- UCNT_W, 16, width of the underflow counter.
- ECNT_W, 8, width of the phase-error counter.

Ports:
- ioclk  in  1  serial-rate clock; the only clock.
- ioclk_rst  in  1  synchronous, active-high reset.
- en  in  1  serializer enable.
- coreclk_ref  in  1  divided clock, sampled as data in the ioclk domain.
- tx_word  in  NUM_LANE*RATIO  parallel word; lane L bit k = tx_word[L*RATIO+k].
- tx_valid  in  1  tx_word valid.
- tx_ready  out  1  word accepted this cycle if tx_valid.
- txd  out  NUM_LANE  registered serial data.
- tx_frame  out  1  registered; high while txd carries bit 0 of a word.
- locked  out  1  state==RUN.
- phase_err  out  1  one-cycle pulse on misaligned reference edge.
- cnt_clr  in  1  synchronous clear of both counters.
- underflow_cnt  out  UCNT_W  saturating count of empty word slots.
- phase_err_cnt  out  ECNT_W  saturating count of phase errors.

Behaviour:
- Reset values: state=IDLE, phase=0, ref_q=0, shreg=0. All outputs 0.
- Edge detect:
  - ref_q <= coreclk_ref every cycle.
  - rise = coreclk_ref & ~ref_q, combinational.
  - No synchronizer: the reference comes from the ioclk domain.
- IDLE: txd=0, tx_frame=0. en=1 → ALIGN.
- ALIGN:
  - Outputs held 0.
  - On rise: go to RUN and set phase<=0, so the first slot is the cycle after rise.
  - en=0 → IDLE.
- RUN:
  - phase increments mod RATIO every cycle.
  - tx_ready = (state==RUN && phase==0), combinational.
  - phase==0, tx_valid=1:
    - shreg <= tx_word.
    - txd <= bit 0 of each lane.
    - tx_frame <= 1.
  - phase==0, tx_valid=0 (underflow):
    - shreg <= 0, txd <= 0, tx_frame <= 1 (the slot is still framed).
    - underflow_cnt++, saturating.
  - phase==k (1..RATIO-1): txd[L] <= shreg[L*RATIO+k], tx_frame <= 0.
- Latency: a word accepted in cycle t appears as lane bit k at txd in cycles t+1+k, k=0..RATIO-1. This gives back-to-back words with no gap.
- Phase check:
  - A rise is expected only when phase==RATIO-1.
  - A rise at any other phase:
    - phase_err pulses for 1 cycle (registered, the next cycle) and phase_err_cnt++, saturating.
    - phase <= 0 (immediate realign) and the in-flight word is truncated.
    - The state stays RUN.
- A missing rise at phase==RATIO-1 is not an error; the counter free-runs.
- en=0 in any state: state=IDLE, txd=0, tx_frame=0, tx_ready=0 the next cycle. Any in-flight word is dropped.
- cnt_clr has priority over an increment in the same cycle.
- Counters hold at their all-ones value.
- Reset mid-word: all registers return to reset values the next cycle, and no partial bits are emitted.

Decomposition:
- Package fsic_io_pkg:
  - state enum {IDLE, ALIGN, RUN}.
  - Default NUM_LANE/RATIO constants.
  - Lane-bit index function (L*RATIO+k).
- One sub-module is natural: fsic_sat_cnt (parameterised width; inc, clr, saturate), instantiated twice.
- Edge detect and the FSM stay inline.

Test Plan:
- Lock: reset, en=1, drive the reference as the ioclk/4 toggle → locked=1 one cycle after the first rise, and tx_ready pulses every 4 cycles starting in the cycle after lock.
- Data: tx_valid held 1, lane 0 nibble 4'b1011, other lanes 0 → txd[0] = 1,1,0,1 over 4 cycles starting one cycle after accept. tx_frame is high on the first of those cycles only.
- Back-to-back: words 0xA then 0x5 per lane → no idle cycle between them; txd shows 0,1,0,1,1,0,1,0.
- Underflow: tx_valid=0 for 3 slots → txd=0 during those slots, underflow_cnt=3. Then cnt_clr → 0.
- Phase slip: insert one extra ioclk into the reference high time → phase_err pulse=1, phase_err_cnt=1, locked stays 1. The next word aligns to the new edge.
- en drop and reset mid-word: deassert en at phase 2 → txd=0 next cycle and state IDLE. Assert ioclk_rst at phase 1 → all outputs 0 next cycle.
